// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: round-robin switch allocator for one output port with credit flow control; define ARB_HOLD_EN for burst holding
module noc_output_arbiter #(
  parameter int N         = 5,
  parameter int W         = 23,
  parameter int MY_PORT   = 0,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N*W-1:0]           head_flit,
  input  logic [N-1:0]             head_vld,
  input  logic                     credit_in,
  output logic [N-1:0]             pop,
  output logic [W-1:0]             out_flit,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   credits,
  output logic                     err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);
  logic [PW-1:0] r_ptr;
  logic [N-1:0]  w_req;
  logic [PW-1:0] w_rr_id;
  logic [PW-1:0] w_gnt_id;
  logic          w_found;
  logic          w_send;
  logic [W-1:0]  w_gnt_flit;
`ifdef ARB_HOLD_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] r_bcnt;
  logic [PW-1:0] r_hold_id;
  logic          r_hold;
  logic          w_hold;
`endif
  // request filter and round-robin search starting at the pointer
  always_comb begin
    w_found = 1'b0;
    w_rr_id = '0;
    for (int i = 0; i < N; i++)
      w_req[i] = head_vld[i] & (head_flit[i*W +: 3] == 3'(MY_PORT));
    for (int k = 0; k < N; k++)
      if (!w_found && w_req[(int'(r_ptr) + k) % N]) begin
        w_found = 1'b1;
        w_rr_id = PW'((int'(r_ptr) + k) % N);
      end
  end
`ifdef ARB_HOLD_EN
  assign w_hold   = r_hold & w_req[r_hold_id] & (r_bcnt < BW'(MAX_BURST));
  assign w_gnt_id = w_hold ? r_hold_id : w_rr_id;
`else
  assign w_gnt_id = w_rr_id;
`endif
  // a zero credit count blocks grants even when a credit returns this cycle
  assign w_send     = w_found & (credits != '0) & ~rst;
  assign pop        = w_send ? (N'(1) << w_gnt_id) : '0;
  assign w_gnt_flit = head_flit[int'(w_gnt_id)*W +: W];
  // output link register, pointer advance and credit tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      out_flit  <= '0;
      out_valid <= 1'b0;
      credits   <= CMAX;
      err       <= 1'b0;
    end else begin
      out_valid <= w_send;
      if (w_send) begin
        out_flit <= w_gnt_flit;
        r_ptr    <= (w_gnt_id == PW'(N-1)) ? '0 : w_gnt_id + 1'b1;
      end
      if (w_send && !credit_in)
        credits <= credits - 1'b1;
      else if (!w_send && credit_in && credits != CMAX)
        credits <= credits + 1'b1;
      if (!w_send && credit_in && credits == CMAX)
        err <= 1'b1;
    end
  end
`ifdef ARB_HOLD_EN
  // burst state: keep the last winner while it still requests and the burst limit allows
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt    <= '0;
      r_hold_id <= '0;
      r_hold    <= 1'b0;
    end else if (w_send) begin
      r_hold_id <= w_gnt_id;
      r_hold    <= 1'b1;
      r_bcnt    <= w_hold ? r_bcnt + 1'b1 : BW'(1);
    end else begin
      r_hold    <= 1'b0;
      r_bcnt    <= '0;
    end
  end
`endif
endmodule
